// File: rtl/com_pkg.sv
// Shared types and widths for the centroid tracker.
package com_pkg;

    localparam int unsigned X_W = 11;
    localparam int unsigned Y_W = 10;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACQUIRE  = 2'd1,
        TRACKING = 2'd2,
        COAST    = 2'd3
    } tracker_state_t;

endpackage

// File: rtl/com_tracker_if.sv
// Centroid-in / tracked-target-out bundle for com_tracker.
// COM_TRACKER_VELOCITY_EN adds the vx_out/vy_out velocity readouts.
interface com_tracker_if;
    import com_pkg::*;

    logic [X_W-1:0] x_in;
    logic [Y_W-1:0] y_in;
    logic           valid_in;
    logic           frame_in;
    logic [X_W-1:0] x_out;
    logic [Y_W-1:0] y_out;
    logic           valid_out;
    logic           locked_out;
    logic [1:0]     state_out;
`ifdef COM_TRACKER_VELOCITY_EN
    logic [X_W:0]   vx_out;
    logic [Y_W:0]   vy_out;
`endif

    modport master (
        output x_in, y_in, valid_in, frame_in,
`ifdef COM_TRACKER_VELOCITY_EN
        input  vx_out, vy_out,
`endif
        input  x_out, y_out, valid_out, locked_out, state_out
    );

    modport slave (
        input  x_in, y_in, valid_in, frame_in,
`ifdef COM_TRACKER_VELOCITY_EN
        output vx_out, vy_out,
`endif
        output x_out, y_out, valid_out, locked_out, state_out
    );

endinterface

// File: rtl/com_tracker_ema_axis.sv
// One axis of the tracker: fixed-point estimate with snap/EMA/hold and jump gate.
// COM_TRACKER_VELOCITY_EN adds a smoothed velocity and dead-reckoning drift.
module ema_axis #(
    parameter int unsigned W           = 11,
    parameter int unsigned ALPHA_SHIFT = 2,
    parameter int unsigned JUMP_THRESH = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] meas,
    input  logic         snap,
    input  logic         update,
`ifdef COM_TRACKER_VELOCITY_EN
    input  logic         vel_clr,
    input  logic         vel_upd,
    input  logic         drift,
    output logic [W:0]   vel_int,
`endif
    output logic [W-1:0] est_int,
    output logic         gate_ok_c
);

    localparam int unsigned EW = W + ALPHA_SHIFT;

    logic [EW-1:0]        est_q, est_n, est_upd_c;
    logic [EW:0]          meas_sh_c;
    logic signed [EW:0]   diff_c, step_c;
    logic signed [W:0]    dist_c;
    logic [W:0]           mag_c;

    assign est_int = est_q[EW-1:ALPHA_SHIFT];

    // Gate on the integer part of the estimate
    always_comb begin
        dist_c    = $signed({1'b0, meas}) - $signed({1'b0, est_int});
        mag_c     = (dist_c < 0) ? (W+1)'(-dist_c) : (W+1)'(dist_c);
        gate_ok_c = (mag_c <= (W+1)'(JUMP_THRESH));
    end

    always_comb begin
        meas_sh_c = (EW+1)'(meas) << ALPHA_SHIFT;
        diff_c    = $signed(meas_sh_c) - $signed({1'b0, est_q});
        step_c    = diff_c >>> ALPHA_SHIFT;
        est_upd_c = EW'($signed({1'b0, est_q}) + step_c);
    end

`ifdef COM_TRACKER_VELOCITY_EN
    localparam int unsigned VW = EW + 1;

    logic signed [VW-1:0] vel_q, vel_n;
    logic signed [VW:0]   dv_c, vstep_c;
    logic signed [EW+1:0] drift_sum_c;
    logic [EW-1:0]        est_drift_c;

    assign vel_int = (W+1)'(vel_q >>> ALPHA_SHIFT);

    // Velocity tracks the smoothed per-frame displacement; drift clamps to the axis range
    always_comb begin
        dv_c    = (VW+1)'($signed({1'b0, est_upd_c})) - (VW+1)'($signed({1'b0, est_q}))
                  - (VW+1)'(vel_q);
        vstep_c = dv_c >>> ALPHA_SHIFT;
        vel_n   = VW'((VW+1)'(vel_q) + vstep_c);
        drift_sum_c = (EW+2)'($signed({1'b0, est_q})) + (EW+2)'(vel_q);
        if (drift_sum_c[EW+1])   est_drift_c = '0;
        else if (drift_sum_c[EW]) est_drift_c = '1;
        else                      est_drift_c = EW'(drift_sum_c);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          vel_q <= '0;
        else if (vel_clr) vel_q <= '0;
        else if (vel_upd) vel_q <= vel_n;
    end
`endif

    always_comb begin
        est_n = est_q;
        if (snap)        est_n = EW'(meas_sh_c);
        else if (update) est_n = est_upd_c;
`ifdef COM_TRACKER_VELOCITY_EN
        else if (drift)  est_n = est_drift_c;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) est_q <= '0;
        else     est_q <= est_n;
    end

endmodule

// File: rtl/com_tracker.sv
// Per-frame centroid tracker: acquire/track/coast FSM over two EMA axes.
// COM_TRACKER_VELOCITY_EN enables velocity estimation and coasting drift.
module com_tracker
    import com_pkg::*;
#(
    parameter int unsigned ACQ_FRAMES  = 3,
    parameter int unsigned LOSS_FRAMES = 8,
    parameter int unsigned ALPHA_SHIFT = 2,
    parameter int unsigned JUMP_THRESH = 64
) (
    input  logic          clk_in,
    input  logic          rst_in,
    com_tracker_if.slave  bus
);

    localparam logic [1:0] ST_IDLE     = 2'(IDLE);
    localparam logic [1:0] ST_ACQUIRE  = 2'(ACQUIRE);
    localparam logic [1:0] ST_TRACKING = 2'(TRACKING);
    localparam logic [1:0] ST_COAST    = 2'(COAST);

    localparam int unsigned AW = $clog2(ACQ_FRAMES + 1);
    localparam int unsigned MW = $clog2(LOSS_FRAMES + 1);

    logic [1:0]     state_q, state_n;
    logic [AW-1:0]  acq_q, acq_n, acq_inc_c;
    logic [MW-1:0]  miss_q, miss_n, miss_inc_c;
    logic [X_W-1:0] meas_x_q, meas_x_c;
    logic [Y_W-1:0] meas_y_q, meas_y_c;
    logic           have_q, have_c;
    logic           valid_q, locked_q;
    logic           gate_x_c, gate_y_c, hit_c;
    logic           snap_c, upd_c;
`ifdef COM_TRACKER_VELOCITY_EN
    logic           vel_clr_c, vel_upd_c, drift_c;
`endif

    // A strobe coincident with frame_in belongs to the frame being closed
    assign meas_x_c   = bus.valid_in ? bus.x_in : meas_x_q;
    assign meas_y_c   = bus.valid_in ? bus.y_in : meas_y_q;
    assign have_c     = bus.valid_in | have_q;
    assign hit_c      = have_c & ((state_q == ST_IDLE) | (gate_x_c & gate_y_c));
    assign acq_inc_c  = (&acq_q)  ? acq_q  : acq_q  + AW'(1);
    assign miss_inc_c = (&miss_q) ? miss_q : miss_q + MW'(1);

    always_comb begin
        state_n = state_q;
        acq_n   = acq_q;
        miss_n  = miss_q;
        snap_c  = 1'b0;
        upd_c   = 1'b0;
`ifdef COM_TRACKER_VELOCITY_EN
        vel_clr_c = 1'b0;
        vel_upd_c = 1'b0;
        drift_c   = 1'b0;
`endif
        if (bus.frame_in) begin
            case (state_q)
                ST_IDLE: if (hit_c) begin
                    snap_c  = 1'b1;
                    acq_n   = AW'(1);
                    state_n = (ACQ_FRAMES <= 1) ? ST_TRACKING : ST_ACQUIRE;
`ifdef COM_TRACKER_VELOCITY_EN
                    vel_clr_c = 1'b1;
`endif
                end
                ST_ACQUIRE: if (hit_c) begin
                    snap_c = 1'b1;
                    acq_n  = acq_inc_c;
                    if (acq_inc_c >= AW'(ACQ_FRAMES)) state_n = ST_TRACKING;
                end else begin
                    acq_n   = '0;
                    state_n = ST_IDLE;
                end
                ST_TRACKING: if (hit_c) begin
                    upd_c = 1'b1;
`ifdef COM_TRACKER_VELOCITY_EN
                    vel_upd_c = 1'b1;
`endif
                end else begin
                    miss_n  = MW'(1);
                    state_n = ST_COAST;
                end
                default: if (hit_c) begin
                    upd_c   = 1'b1;
                    miss_n  = '0;
                    state_n = ST_TRACKING;
                end else begin
                    miss_n = miss_inc_c;
`ifdef COM_TRACKER_VELOCITY_EN
                    drift_c = 1'b1;
`endif
                    if (miss_inc_c >= MW'(LOSS_FRAMES)) begin
                        miss_n  = '0;
                        state_n = ST_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q  <= ST_IDLE;
            acq_q    <= '0;
            miss_q   <= '0;
            meas_x_q <= '0;
            meas_y_q <= '0;
            have_q   <= 1'b0;
            valid_q  <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_n;
            acq_q    <= acq_n;
            miss_q   <= miss_n;
            meas_x_q <= meas_x_c;
            meas_y_q <= meas_y_c;
            have_q   <= bus.frame_in ? 1'b0 : have_c;
            valid_q  <= bus.frame_in & ((state_n == ST_TRACKING) | (state_n == ST_COAST));
            locked_q <= (state_n == ST_TRACKING);
        end
    end

    ema_axis #(.W(X_W), .ALPHA_SHIFT(ALPHA_SHIFT), .JUMP_THRESH(JUMP_THRESH)) u_axis_x (
        .clk       (clk_in),
        .rst       (rst_in),
        .meas      (meas_x_c),
        .snap      (snap_c),
        .update    (upd_c),
`ifdef COM_TRACKER_VELOCITY_EN
        .vel_clr   (vel_clr_c),
        .vel_upd   (vel_upd_c),
        .drift     (drift_c),
        .vel_int   (bus.vx_out),
`endif
        .est_int   (bus.x_out),
        .gate_ok_c (gate_x_c)
    );

    ema_axis #(.W(Y_W), .ALPHA_SHIFT(ALPHA_SHIFT), .JUMP_THRESH(JUMP_THRESH)) u_axis_y (
        .clk       (clk_in),
        .rst       (rst_in),
        .meas      (meas_y_c),
        .snap      (snap_c),
        .update    (upd_c),
`ifdef COM_TRACKER_VELOCITY_EN
        .vel_clr   (vel_clr_c),
        .vel_upd   (vel_upd_c),
        .drift     (drift_c),
        .vel_int   (bus.vy_out),
`endif
        .est_int   (bus.y_out),
        .gate_ok_c (gate_y_c)
    );

    assign bus.state_out  = state_q;
    assign bus.valid_out  = valid_q;
    assign bus.locked_out = locked_q;

endmodule

// File: tb/tb_com_tracker.sv
// Self-checking bench for com_tracker: directed scenarios plus random frames
// compared against a frame-level reference model.
module tb_com_tracker;
    import com_pkg::*;

    localparam int AS   = 2;
    localparam int ACQ  = 3;
    localparam int LOSS = 8;
    localparam int JT   = 64;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;

    com_tracker_if bus ();

    com_tracker dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    // reference model: state 0..3, estimates in 1/2^AS pixel units
    int m_state, m_ex, m_ey, m_acq, m_miss;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    function automatic int absi(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int floor_div(input int n, input int d);
        return (n >= 0) ? n / d : -((-n + d - 1) / d);
    endfunction

    function automatic int clampi(input int v, input int hi);
        return (v < 0) ? 0 : ((v > hi) ? hi : v);
    endfunction

    task automatic model_reset();
        m_state = 0; m_ex = 0; m_ey = 0; m_acq = 0; m_miss = 0;
    endtask

    task automatic model_frame(input bit has, input int x, input int y);
        bit hit;
        int sc;
        sc  = 1 << AS;
        hit = has && (m_state == 0 ||
              (absi(x - m_ex / sc) <= JT && absi(y - m_ey / sc) <= JT));
        case (m_state)
            0: if (hit) begin
                m_ex = x * sc; m_ey = y * sc; m_acq = 1;
                m_state = (ACQ == 1) ? 2 : 1;
            end
            1: if (hit) begin
                m_ex = x * sc; m_ey = y * sc; m_acq++;
                if (m_acq >= ACQ) m_state = 2;
            end else begin
                m_state = 0; m_acq = 0;
            end
            2: if (hit) begin
                m_ex += floor_div(x * sc - m_ex, sc);
                m_ey += floor_div(y * sc - m_ey, sc);
            end else begin
                m_state = 3; m_miss = 1;
            end
            default: if (hit) begin
                m_ex += floor_div(x * sc - m_ex, sc);
                m_ey += floor_div(y * sc - m_ey, sc);
                m_miss = 0; m_state = 2;
            end else begin
                m_miss++;
                if (m_miss >= LOSS) begin
                    m_state = 0; m_miss = 0;
                end
            end
        endcase
    endtask

    task automatic check_outputs(input string tag, input bit exp_valid);
        check({tag, ".valid"},  int'(bus.valid_out),  int'(exp_valid));
        check({tag, ".x"},      int'(bus.x_out),      m_ex / (1 << AS));
        check({tag, ".y"},      int'(bus.y_out),      m_ey / (1 << AS));
        check({tag, ".locked"}, int'(bus.locked_out), (m_state == 2) ? 1 : 0);
        check({tag, ".state"},  int'(bus.state_out),  m_state);
    endtask

    // One frame: optional decoy strobe, the measurement (before or with frame_in), then frame_in
    task automatic run_frame(input bit has, input int x, input int y,
                             input bit coinc, input bit dbl, input string tag);
        if (has && dbl) begin
            bus.valid_in = 1'b1;
            bus.x_in = 11'($urandom_range(0, 2047));
            bus.y_in = 10'($urandom_range(0, 1023));
            tick();
        end
        if (has && !coinc) begin
            bus.valid_in = 1'b1;
            bus.x_in = 11'(x);
            bus.y_in = 10'(y);
            tick();
        end
        bus.valid_in = has && coinc;
        if (has && coinc) begin
            bus.x_in = 11'(x);
            bus.y_in = 10'(y);
        end
        bus.frame_in = 1'b1;
        tick();
        bus.frame_in = 1'b0;
        bus.valid_in = 1'b0;
        model_frame(has, x, y);
        check_outputs(tag, (m_state == 2 || m_state == 3));
        tick();
        check({tag, ".pulse_end"}, int'(bus.valid_out), 0);
    endtask

    initial begin
        int rx, ry;
        bit has, far_jump;
        bus.x_in = '0;
        bus.y_in = '0;
        bus.valid_in = 1'b0;
        bus.frame_in = 1'b0;
        model_reset();

        repeat (3) tick();
        check_outputs("reset", 1'b0);
        rst_in = 1'b0;
        tick();

        // acquisition at (100,50)
        run_frame(1, 100, 50, 0, 0, "acq1");
        check("acq1.state_c", int'(bus.state_out), 1);
        run_frame(1, 100, 50, 0, 0, "acq2");
        run_frame(1, 100, 50, 0, 0, "acq3");
        check("lock.x_c", int'(bus.x_out), 100);
        check("lock.locked_c", int'(bus.locked_out), 1);

        // gated jump coasts, nearby hit relocks
        run_frame(1, 300, 50, 0, 0, "jump");
        check("jump.state_c", int'(bus.state_out), 3);
        run_frame(1, 101, 50, 0, 0, "relock");

        // EMA steps toward 108
        run_frame(1, 108, 50, 0, 0, "ema1");
        check("ema1.x_c", int'(bus.x_out), 102);
        run_frame(1, 108, 50, 0, 0, "ema2");
        check("ema2.x_c", int'(bus.x_out), 103);

        // short loss then recovery
        for (int i = 0; i < 5; i++) run_frame(0, 0, 0, 0, 0, "short_miss");
        run_frame(1, 105, 52, 0, 0, "recover");
        check("recover.locked_c", int'(bus.locked_out), 1);

        // full loss: seven coast frames then IDLE
        for (int i = 0; i < LOSS; i++) run_frame(0, 0, 0, 0, 0, "loss");
        check("loss.state_c", int'(bus.state_out), 0);

        // coincident strobe, then last-of-two wins
        run_frame(1, 200, 100, 1, 0, "coinc");
        check("coinc.x_c", int'(bus.x_out), 200);
        run_frame(1, 202, 101, 0, 1, "double");
        check("double.x_c", int'(bus.x_out), 202);
        run_frame(1, 203, 99, 1, 1, "double_coinc");

        // asynchronous reset mid-cycle while tracking
        check("pre_rst.locked", int'(bus.locked_out), 1);
        @(posedge clk_in);
        #3 rst_in = 1'b1;
        #1;
        model_reset();
        check_outputs("async_rst", 1'b0);
        tick();
        rst_in = 1'b0;
        tick();

        // pending measurement discarded by reset
        bus.valid_in = 1'b1;
        bus.x_in = 11'd500;
        bus.y_in = 10'd200;
        tick();
        bus.valid_in = 1'b0;
        #2 rst_in = 1'b1;
        #2 rst_in = 1'b0;
        tick();
        run_frame(0, 0, 0, 0, 0, "pending_drop");
        run_frame(1, 40, 30, 0, 0, "post_rst1");
        run_frame(1, 40, 30, 0, 0, "post_rst2");
        check("post_rst2.locked_c", int'(bus.locked_out), 0);
        run_frame(1, 40, 30, 0, 0, "post_rst3");

        // random frames
        for (int n = 0; n < 400; n++) begin
            has      = ($urandom_range(0, 4) != 0);
            far_jump = ($urandom_range(0, 7) == 0);
            if (far_jump) begin
                rx = int'($urandom_range(0, 2047));
                ry = int'($urandom_range(0, 1023));
            end else begin
                rx = clampi(m_ex / (1 << AS) + int'($urandom_range(0, 140)) - 70, 2047);
                ry = clampi(m_ey / (1 << AS) + int'($urandom_range(0, 140)) - 70, 1023);
            end
            run_frame(has, rx, ry, bit'($urandom_range(0, 1)),
                      ($urandom_range(0, 3) == 0), "rand");
            repeat ($urandom_range(0, 2)) begin
                tick();
                check("rand.idle_valid", int'(bus.valid_out), 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
